// File: rtl/iob_iob2axil_pkg.sv
// Shared types for the IOb-to-AXI-Lite bridge: FSM encoding and AXI response codes.
package iob_iob2axil_pkg;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_WR     = 3'd1,
      ST_WAIT_B = 3'd2,
      ST_ACK    = 3'd3,
      ST_RD_A   = 3'd4,
      ST_WAIT_R = 3'd5,
      ST_RVAL   = 3'd6
   } state_t;

   localparam logic [1:0] AXI_OKAY   = 2'b00;
   localparam logic [1:0] AXI_SLVERR = 2'b10;
   localparam logic [1:0] AXI_DECERR = 2'b11;

   function automatic logic resp_is_err(input logic [1:0] resp);
      return resp != AXI_OKAY;
   endfunction

endpackage

// File: rtl/iob_iob2axil_reg.sv
// Enable/reset register primitive: async active-low clear, update when cke and en are both high.
module iob_iob2axil_reg #(
   parameter int W = 1
) (
   input  logic         clk_i,
   input  logic         arst_n_i,
   input  logic         cke_i,
   input  logic         en_i,
   input  logic [W-1:0] d_i,
   output logic [W-1:0] q_o
);

   always_ff @(posedge clk_i or negedge arst_n_i) begin
      if (!arst_n_i) begin
         q_o <= '0;
      end else if (cke_i && en_i) begin
         q_o <= d_i;
      end
   end

endmodule

// File: rtl/iob_iob2axil.sv
// IOb subordinate to AXI-Lite manager bridge, one transaction in flight at a time.
// Valid/ready: a transfer happens on any clock edge (with cke_i high) where valid and ready are both 1.
module iob_iob2axil
   import iob_iob2axil_pkg::*;
#(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
) (
   input  logic                clk_i,
   input  logic                cke_i,
   input  logic                arst_n_i,
   input  logic                iob_valid_i,
   input  logic [ADDR_W-1:0]   iob_addr_i,
   input  logic [DATA_W-1:0]   iob_wdata_i,
   input  logic [DATA_W/8-1:0] iob_wstrb_i,
   output logic                iob_ready_o,
   output logic                iob_rvalid_o,
   output logic [DATA_W-1:0]   iob_rdata_o,
   input  logic                iob_rready_i,
   output logic [ADDR_W-1:0]   axil_awaddr_o,
   output logic                axil_awvalid_o,
   input  logic                axil_awready_i,
   output logic [DATA_W-1:0]   axil_wdata_o,
   output logic [DATA_W/8-1:0] axil_wstrb_o,
   output logic                axil_wvalid_o,
   input  logic                axil_wready_i,
   input  logic [1:0]          axil_bresp_i,
   input  logic                axil_bvalid_i,
   output logic                axil_bready_o,
   output logic [ADDR_W-1:0]   axil_araddr_o,
   output logic                axil_arvalid_o,
   input  logic                axil_arready_i,
   input  logic [DATA_W-1:0]   axil_rdata_i,
   input  logic [1:0]          axil_rresp_i,
   input  logic                axil_rvalid_i,
   output logic                axil_rready_o,
   output logic                resp_err_o,
   output logic [2:0]          dbg_state_o
);

   localparam int STRB_W = DATA_W / 8;

   state_t r_state;
   logic   r_awvalid;
   logic   r_wvalid;
   logic   r_arvalid;
   logic   r_aw_done;
   logic   r_w_done;
   logic   r_rd_ack;
   logic   r_resp_err;

   logic              w_capture;
   logic              w_rdata_en;
   logic              w_aw_hs;
   logic              w_w_hs;
   logic              w_aw_fin;
   logic              w_w_fin;
   logic [ADDR_W-1:0] w_addr;

   assign w_capture  = (r_state == ST_IDLE) && iob_valid_i;
   assign w_rdata_en = (r_state == ST_WAIT_R) && axil_rvalid_i;
   assign w_aw_hs    = r_awvalid && axil_awready_i;
   assign w_w_hs     = r_wvalid && axil_wready_i;
   // A channel counts as finished if it completed earlier or is completing this cycle.
   assign w_aw_fin   = r_aw_done || w_aw_hs;
   assign w_w_fin    = r_w_done || w_w_hs;

   iob_iob2axil_reg #(.W(ADDR_W)) u_addr_reg (
      .clk_i(clk_i), .arst_n_i(arst_n_i), .cke_i(cke_i),
      .en_i(w_capture), .d_i(iob_addr_i), .q_o(w_addr)
   );

   iob_iob2axil_reg #(.W(DATA_W)) u_wdata_reg (
      .clk_i(clk_i), .arst_n_i(arst_n_i), .cke_i(cke_i),
      .en_i(w_capture), .d_i(iob_wdata_i), .q_o(axil_wdata_o)
   );

   iob_iob2axil_reg #(.W(STRB_W)) u_wstrb_reg (
      .clk_i(clk_i), .arst_n_i(arst_n_i), .cke_i(cke_i),
      .en_i(w_capture), .d_i(iob_wstrb_i), .q_o(axil_wstrb_o)
   );

   iob_iob2axil_reg #(.W(DATA_W)) u_rdata_reg (
      .clk_i(clk_i), .arst_n_i(arst_n_i), .cke_i(cke_i),
      .en_i(w_rdata_en), .d_i(axil_rdata_i), .q_o(iob_rdata_o)
   );

   always_ff @(posedge clk_i or negedge arst_n_i) begin
      if (!arst_n_i) begin
         r_state    <= ST_IDLE;
         r_awvalid  <= 1'b0;
         r_wvalid   <= 1'b0;
         r_arvalid  <= 1'b0;
         r_aw_done  <= 1'b0;
         r_w_done   <= 1'b0;
         r_rd_ack   <= 1'b0;
         r_resp_err <= 1'b0;
      end else if (cke_i) begin
         r_rd_ack   <= 1'b0;
         r_resp_err <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               if (iob_valid_i) begin
                  if (|iob_wstrb_i) begin
                     r_state   <= ST_WR;
                     r_awvalid <= 1'b1;
                     r_wvalid  <= 1'b1;
                     r_aw_done <= 1'b0;
                     r_w_done  <= 1'b0;
                  end else begin
                     r_state   <= ST_RD_A;
                     r_arvalid <= 1'b1;
                  end
               end
            end
            ST_WR: begin
               if (w_aw_hs) begin
                  r_awvalid <= 1'b0;
                  r_aw_done <= 1'b1;
               end
               if (w_w_hs) begin
                  r_wvalid <= 1'b0;
                  r_w_done <= 1'b1;
               end
               if (w_aw_fin && w_w_fin) begin
                  r_state <= ST_WAIT_B;
               end
            end
            ST_WAIT_B: begin
               if (axil_bvalid_i) begin
                  r_state    <= ST_ACK;
                  r_resp_err <= resp_is_err(axil_bresp_i);
               end
            end
            ST_ACK: begin
               r_state <= ST_IDLE;
            end
            ST_RD_A: begin
               if (r_arvalid && axil_arready_i) begin
                  r_arvalid <= 1'b0;
                  r_rd_ack  <= 1'b1;
                  r_state   <= ST_WAIT_R;
               end
            end
            ST_WAIT_R: begin
               if (axil_rvalid_i) begin
                  r_state    <= ST_RVAL;
                  r_resp_err <= resp_is_err(axil_rresp_i);
               end
            end
            ST_RVAL: begin
               if (iob_rready_i) begin
                  r_state <= ST_IDLE;
               end
            end
            default: begin
               r_state <= ST_IDLE;
            end
         endcase
      end
   end

   // Reads acknowledge on the pulse after AR; writes acknowledge from the ACK state.
   assign iob_ready_o    = (r_state == ST_ACK) || r_rd_ack;
   assign iob_rvalid_o   = (r_state == ST_RVAL);
   assign axil_bready_o  = (r_state == ST_WAIT_B);
   assign axil_rready_o  = (r_state == ST_WAIT_R);
   assign axil_awvalid_o = r_awvalid;
   assign axil_wvalid_o  = r_wvalid;
   assign axil_arvalid_o = r_arvalid;
   assign axil_awaddr_o  = w_addr;
   assign axil_araddr_o  = w_addr;
   assign resp_err_o     = r_resp_err;
   assign dbg_state_o    = r_state;

endmodule

// File: tb/tb_iob_iob2axil.sv
// Directed bench for the IOb-to-AXI-Lite bridge; the AXI-Lite slave is modelled inline per scenario.
module tb_iob_iob2axil;
   import iob_iob2axil_pkg::*;

   logic        clk = 1'b0;
   logic        cke;
   logic        arst_n;
   logic        iob_valid;
   logic [31:0] iob_addr;
   logic [31:0] iob_wdata;
   logic [3:0]  iob_wstrb;
   logic        iob_ready_o;
   logic        iob_rvalid_o;
   logic [31:0] iob_rdata_o;
   logic        iob_rready;
   logic [31:0] axil_awaddr_o;
   logic        axil_awvalid_o;
   logic        awready;
   logic [31:0] axil_wdata_o;
   logic [3:0]  axil_wstrb_o;
   logic        axil_wvalid_o;
   logic        wready;
   logic [1:0]  bresp;
   logic        bvalid;
   logic        axil_bready_o;
   logic [31:0] axil_araddr_o;
   logic        axil_arvalid_o;
   logic        arready;
   logic [31:0] rdata;
   logic [1:0]  rresp;
   logic        rvalid;
   logic        axil_rready_o;
   logic        resp_err_o;
   logic [2:0]  dbg_state_o;

   int checks = 0;
   int failures = 0;

   always #5 clk = ~clk;

   iob_iob2axil #(.ADDR_W(32), .DATA_W(32)) dut (
      .clk_i(clk), .cke_i(cke), .arst_n_i(arst_n),
      .iob_valid_i(iob_valid), .iob_addr_i(iob_addr), .iob_wdata_i(iob_wdata),
      .iob_wstrb_i(iob_wstrb), .iob_ready_o(iob_ready_o), .iob_rvalid_o(iob_rvalid_o),
      .iob_rdata_o(iob_rdata_o), .iob_rready_i(iob_rready),
      .axil_awaddr_o(axil_awaddr_o), .axil_awvalid_o(axil_awvalid_o), .axil_awready_i(awready),
      .axil_wdata_o(axil_wdata_o), .axil_wstrb_o(axil_wstrb_o), .axil_wvalid_o(axil_wvalid_o),
      .axil_wready_i(wready), .axil_bresp_i(bresp), .axil_bvalid_i(bvalid),
      .axil_bready_o(axil_bready_o), .axil_araddr_o(axil_araddr_o), .axil_arvalid_o(axil_arvalid_o),
      .axil_arready_i(arready), .axil_rdata_i(rdata), .axil_rresp_i(rresp), .axil_rvalid_i(rvalid),
      .axil_rready_o(axil_rready_o), .resp_err_o(resp_err_o), .dbg_state_o(dbg_state_o)
   );

   task automatic idle_inputs();
      iob_valid = 0; iob_addr = '0; iob_wdata = '0; iob_wstrb = '0; iob_rready = 0;
      awready = 0; wready = 0; bvalid = 0; bresp = 2'b00;
      arready = 0; rvalid = 0; rdata = '0; rresp = 2'b00;
   endtask

   // Runs one write against a slave with programmable AW/W wait states; returns event counts.
   task automatic do_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb,
                           input int aw_dly, input int w_dly, input logic [1:0] resp,
                           output int n_ready, output int n_err, output int n_b,
                           output int n_aw, output int n_w, output bit tmo);
      bit done;
      n_ready = 0; n_err = 0; n_b = 0; n_aw = 0; n_w = 0; done = 0;
      iob_valid = 1; iob_addr = addr; iob_wdata = data; iob_wstrb = strb;
      for (int c = 0; c < 40 && !done; c++) begin
         @(negedge clk);
         if (iob_ready_o) begin n_ready++; iob_valid = 0; done = 1; end
         if (resp_err_o) n_err++;
         if (axil_awvalid_o) n_aw++;
         if (axil_wvalid_o) n_w++;
         awready = axil_awvalid_o && (n_aw > aw_dly);
         wready  = axil_wvalid_o && (n_w > w_dly);
         bvalid  = axil_bready_o && (n_b == 0);
         bresp   = bvalid ? resp : 2'b00;
         if (axil_bready_o && bvalid) n_b++;
      end
      tmo = !done;
      for (int t = 0; t < 3; t++) begin
         @(negedge clk);
         if (iob_ready_o) n_ready++;
         if (resp_err_o) n_err++;
         if (axil_bready_o && bvalid) n_b++;
         awready = 0; wready = 0; bvalid = 0;
      end
   endtask

   // Runs one read; slave answers r_dly cycles into WAIT_R, requester holds rready low for hold cycles.
   task automatic do_read(input logic [31:0] addr, input logic [31:0] data, input logic [1:0] resp,
                          input int r_dly, input int hold,
                          output int n_ready, output int n_err, output int n_rv,
                          output logic [31:0] got, output logic rv_drop, output bit tmo);
      int n_wr;
      bit done;
      n_ready = 0; n_err = 0; n_rv = 0; got = '0; rv_drop = 1'b1; n_wr = 0; done = 0;
      iob_valid = 1; iob_addr = addr; iob_wstrb = 4'h0; iob_rready = 0;
      for (int c = 0; c < 40 && !done; c++) begin
         @(negedge clk);
         if (iob_ready_o) begin n_ready++; iob_valid = 0; end
         if (resp_err_o) n_err++;
         if (iob_rvalid_o) begin
            n_rv++;
            got = iob_rdata_o;
            if (n_rv > hold) begin iob_rready = 1; done = 1; end
         end
         arready = axil_arvalid_o;
         if (axil_rready_o) n_wr++;
         rvalid = axil_rready_o && (n_wr > r_dly);
         rdata  = rvalid ? data : 32'hDEAD_BEEF;
         rresp  = rvalid ? resp : 2'b00;
      end
      tmo = !done;
      for (int t = 0; t < 3; t++) begin
         @(negedge clk);
         if (t == 0) rv_drop = iob_rvalid_o;
         if (iob_ready_o) n_ready++;
         if (resp_err_o) n_err++;
         iob_rready = 0; rvalid = 0; arready = 0;
      end
   endtask

   task automatic test_reset();
      idle_inputs();
      cke = 1; arst_n = 0;
      repeat (3) @(negedge clk);
      checks++;
      if ({iob_ready_o, iob_rvalid_o, axil_awvalid_o, axil_wvalid_o, axil_arvalid_o,
           axil_bready_o, axil_rready_o, resp_err_o} !== 8'h00) begin
         failures++; $display("FAIL reset_ctrl got=%b required=0", {iob_ready_o, iob_rvalid_o,
            axil_awvalid_o, axil_wvalid_o, axil_arvalid_o, axil_bready_o, axil_rready_o, resp_err_o});
      end
      checks++;
      if ({axil_awaddr_o, axil_araddr_o, axil_wdata_o, axil_wstrb_o, iob_rdata_o} !== 132'h0) begin
         failures++; $display("FAIL reset_data got aw=%h ar=%h wd=%h ws=%h rd=%h required=0",
            axil_awaddr_o, axil_araddr_o, axil_wdata_o, axil_wstrb_o, iob_rdata_o);
      end
      arst_n = 1;
      @(negedge clk);
      checks++;
      if (dbg_state_o !== ST_IDLE) begin
         failures++; $display("FAIL reset_state got=%0d required=%0d", dbg_state_o, ST_IDLE);
      end
   endtask

   task automatic test_write_basic();
      idle_inputs();
      awready = 1; wready = 1;
      iob_valid = 1; iob_addr = 32'h10; iob_wdata = 32'hA5A5_0001; iob_wstrb = 4'hF;
      @(negedge clk);
      checks++;
      if ({axil_awvalid_o, axil_wvalid_o, axil_bready_o, iob_ready_o, axil_arvalid_o} !== 5'b11000) begin
         failures++; $display("FAIL wr_c1_ctrl got=%b required=11000",
            {axil_awvalid_o, axil_wvalid_o, axil_bready_o, iob_ready_o, axil_arvalid_o});
      end
      checks++;
      if ({axil_awaddr_o, axil_wdata_o, axil_wstrb_o} !== {32'h10, 32'hA5A5_0001, 4'hF}) begin
         failures++; $display("FAIL wr_c1_data got=%h/%h/%h required=10/a5a50001/f",
            axil_awaddr_o, axil_wdata_o, axil_wstrb_o);
      end
      @(negedge clk);
      checks++;
      if ({axil_awvalid_o, axil_wvalid_o, axil_bready_o, iob_ready_o} !== 4'b0010) begin
         failures++; $display("FAIL wr_c2_bready got=%b required=0010",
            {axil_awvalid_o, axil_wvalid_o, axil_bready_o, iob_ready_o});
      end
      bvalid = 1; bresp = AXI_OKAY;
      @(negedge clk);
      checks++;
      if ({iob_ready_o, axil_bready_o, resp_err_o} !== 3'b100) begin
         failures++; $display("FAIL wr_c3_ack got=%b required=100", {iob_ready_o, axil_bready_o, resp_err_o});
      end
      bvalid = 0; iob_valid = 0;
      @(negedge clk);
      checks++;
      if ({iob_ready_o, resp_err_o, dbg_state_o} !== {2'b00, ST_IDLE} || axil_awaddr_o !== 32'h10) begin
         failures++; $display("FAIL wr_c4_idle got ready=%b err=%b st=%0d awaddr=%h required 0/0/0/10",
            iob_ready_o, resp_err_o, dbg_state_o, axil_awaddr_o);
      end
      awready = 0; wready = 0;
   endtask

   task automatic test_write_aw_delay();
      int n_ready, n_err, n_b, n_aw, n_w;
      bit tmo;
      idle_inputs();
      do_write(32'h20, 32'h1234_5678, 4'h3, 3, 0, AXI_OKAY, n_ready, n_err, n_b, n_aw, n_w, tmo);
      checks++;
      if (tmo !== 1'b0) begin failures++; $display("FAIL awdly_timeout got=%0d required=0", tmo); end
      checks++;
      if (n_aw !== 4 || n_w !== 1) begin
         failures++; $display("FAIL awdly_valid_cycles got aw=%0d w=%0d required aw=4 w=1", n_aw, n_w);
      end
      checks++;
      if (n_b !== 1 || n_ready !== 1 || n_err !== 0) begin
         failures++; $display("FAIL awdly_completion got b=%0d ready=%0d err=%0d required 1/1/0",
            n_b, n_ready, n_err);
      end
   endtask

   task automatic test_read_hold();
      idle_inputs();
      arready = 1;
      iob_valid = 1; iob_addr = 32'h8; iob_wstrb = 4'h0;
      @(negedge clk);
      checks++;
      if ({axil_arvalid_o, axil_awvalid_o, iob_ready_o} !== 3'b100 || axil_araddr_o !== 32'h8) begin
         failures++; $display("FAIL rd_c1_ar got arv=%b awv=%b rdy=%b araddr=%h required 1/0/0/8",
            axil_arvalid_o, axil_awvalid_o, iob_ready_o, axil_araddr_o);
      end
      @(negedge clk);
      checks++;
      if ({axil_arvalid_o, iob_ready_o, axil_rready_o} !== 3'b011) begin
         failures++; $display("FAIL rd_c2_ready got=%b required=011", {axil_arvalid_o, iob_ready_o, axil_rready_o});
      end
      iob_valid = 0; arready = 0;
      @(negedge clk);
      checks++;
      if ({iob_ready_o, iob_rvalid_o, axil_rready_o} !== 3'b001) begin
         failures++; $display("FAIL rd_c3_wait got=%b required=001", {iob_ready_o, iob_rvalid_o, axil_rready_o});
      end
      rvalid = 1; rdata = 32'h0000_0081; rresp = AXI_OKAY;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         rvalid = 0; rdata = 32'hDEAD_BEEF;
         checks++;
         if ({iob_rvalid_o, axil_rready_o, resp_err_o, iob_ready_o} !== 4'b1000 || iob_rdata_o !== 32'h81) begin
            failures++; $display("FAIL rd_hold%0d got rv=%b rr=%b err=%b rdy=%b data=%h required 1/0/0/0/81",
               i, iob_rvalid_o, axil_rready_o, resp_err_o, iob_ready_o, iob_rdata_o);
         end
      end
      iob_rready = 1;
      @(negedge clk);
      iob_rready = 0;
      checks++;
      if (iob_rvalid_o !== 1'b0 || dbg_state_o !== ST_IDLE || iob_rdata_o !== 32'h81) begin
         failures++; $display("FAIL rd_drop got rv=%b st=%0d data=%h required 0/0/81",
            iob_rvalid_o, dbg_state_o, iob_rdata_o);
      end
   endtask

   task automatic test_error_resp();
      int n_ready, n_err, n_rv, n_b, n_aw, n_w;
      logic [31:0] got;
      logic rv_drop;
      bit tmo;
      idle_inputs();
      do_read(32'h30, 32'h0000_0077, AXI_SLVERR, 0, 0, n_ready, n_err, n_rv, got, rv_drop, tmo);
      checks++;
      if (tmo !== 1'b0 || n_ready !== 1 || n_err !== 1) begin
         failures++; $display("FAIL err_rd_pulses got tmo=%0d ready=%0d err=%0d required 0/1/1", tmo, n_ready, n_err);
      end
      checks++;
      if (got !== 32'h77 || rv_drop !== 1'b0) begin
         failures++; $display("FAIL err_rd_data got data=%h drop=%b required 77/0", got, rv_drop);
      end
      do_write(32'h34, 32'h0BAD_0002, 4'h8, 0, 0, AXI_DECERR, n_ready, n_err, n_b, n_aw, n_w, tmo);
      checks++;
      if (tmo !== 1'b0 || n_ready !== 1 || n_err !== 1 || n_b !== 1) begin
         failures++; $display("FAIL err_wr_pulses got tmo=%0d ready=%0d err=%0d b=%0d required 0/1/1/1",
            tmo, n_ready, n_err, n_b);
      end
   endtask

   task automatic test_back_to_back();
      int c_ack, c_ar, c_rack, n_both, n_aw;
      logic [31:0] got;
      bit done;
      idle_inputs();
      awready = 1; wready = 1; arready = 1;
      iob_valid = 1; iob_addr = 32'h40; iob_wdata = 32'hCAFE_0005; iob_wstrb = 4'hF;
      c_ack = -1; c_ar = -1; c_rack = -1; n_both = 0; n_aw = 0; got = '0; done = 0;
      for (int c = 1; c <= 40 && !done; c++) begin
         @(negedge clk);
         if ((axil_awvalid_o || axil_wvalid_o) && axil_arvalid_o) n_both++;
         if (axil_awvalid_o) n_aw++;
         if (axil_arvalid_o && c_ar < 0) c_ar = c;
         if (iob_ready_o) begin
            if (c_ack < 0) begin c_ack = c; iob_wstrb = 4'h0; iob_addr = 32'h44; end
            else begin c_rack = c; iob_valid = 0; end
         end
         bvalid = axil_bready_o;
         rvalid = axil_rready_o;
         rdata  = 32'h0BAD_F00D;
         if (iob_rvalid_o) begin got = iob_rdata_o; iob_rready = 1; done = 1; end
      end
      @(negedge clk);
      idle_inputs();
      checks++;
      if (done !== 1'b1 || c_ack !== 3 || c_ar !== 5 || c_rack !== 6) begin
         failures++; $display("FAIL b2b_timing got done=%0d ack=%0d ar=%0d rack=%0d required 1/3/5/6",
            done, c_ack, c_ar, c_rack);
      end
      checks++;
      if (n_both !== 0 || n_aw !== 1 || got !== 32'h0BAD_F00D) begin
         failures++; $display("FAIL b2b_overlap got both=%0d aw=%0d data=%h required 0/1/0badf00d",
            n_both, n_aw, got);
      end
   endtask

   task automatic test_cke_freeze();
      idle_inputs();
      iob_valid = 1; iob_addr = 32'h50; iob_wdata = 32'h0000_00EE; iob_wstrb = 4'h1;
      @(negedge clk);
      cke = 0; awready = 1; wready = 1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         checks++;
         if ({axil_awvalid_o, axil_wvalid_o} !== 2'b11 || dbg_state_o !== ST_WR || axil_awaddr_o !== 32'h50) begin
            failures++; $display("FAIL cke_freeze%0d got awv=%b wv=%b st=%0d addr=%h required 1/1/1/50",
               i, axil_awvalid_o, axil_wvalid_o, dbg_state_o, axil_awaddr_o);
         end
      end
      cke = 1;
      @(negedge clk);
      checks++;
      if ({axil_awvalid_o, axil_wvalid_o, axil_bready_o} !== 3'b001 || dbg_state_o !== ST_WAIT_B) begin
         failures++; $display("FAIL cke_resume got=%b st=%0d required 001/2",
            {axil_awvalid_o, axil_wvalid_o, axil_bready_o}, dbg_state_o);
      end
      bvalid = 1; awready = 0; wready = 0;
      @(negedge clk);
      checks++;
      if (iob_ready_o !== 1'b1) begin failures++; $display("FAIL cke_ack got=%b required=1", iob_ready_o); end
      bvalid = 0; iob_valid = 0;
      @(negedge clk);
   endtask

   task automatic test_reset_mid();
      int n_ready, n_err, n_rv;
      logic [31:0] got;
      logic rv_drop;
      bit tmo;
      idle_inputs();
      awready = 1; wready = 1;
      iob_valid = 1; iob_addr = 32'h60; iob_wdata = 32'h1111_2222; iob_wstrb = 4'hF;
      repeat (2) @(negedge clk);
      checks++;
      if (dbg_state_o !== ST_WAIT_B || axil_bready_o !== 1'b1) begin
         failures++; $display("FAIL rstmid_waitb got st=%0d bready=%b required 2/1", dbg_state_o, axil_bready_o);
      end
      #2 arst_n = 0;
      #1;
      checks++;
      if ({iob_ready_o, iob_rvalid_o, axil_awvalid_o, axil_wvalid_o, axil_arvalid_o, axil_bready_o,
           axil_rready_o, resp_err_o, dbg_state_o} !== 11'h0 ||
          {axil_awaddr_o, axil_wdata_o, axil_wstrb_o, iob_rdata_o} !== 100'h0) begin
         failures++; $display("FAIL rstmid_clear got st=%0d bready=%b awaddr=%h wdata=%h wstrb=%h required all 0",
            dbg_state_o, axil_bready_o, axil_awaddr_o, axil_wdata_o, axil_wstrb_o);
      end
      idle_inputs();
      @(negedge clk);
      arst_n = 1;
      @(negedge clk);
      do_read(32'h64, 32'h5A5A_0003, AXI_OKAY, 1, 2, n_ready, n_err, n_rv, got, rv_drop, tmo);
      checks++;
      if (tmo !== 1'b0 || n_ready !== 1 || n_err !== 0 || n_rv !== 3) begin
         failures++; $display("FAIL rstmid_read_flow got tmo=%0d ready=%0d err=%0d rv=%0d required 0/1/0/3",
            tmo, n_ready, n_err, n_rv);
      end
      checks++;
      if (got !== 32'h5A5A_0003 || rv_drop !== 1'b0) begin
         failures++; $display("FAIL rstmid_read_data got data=%h drop=%b required 5a5a0003/0", got, rv_drop);
      end
   endtask

   initial begin
      test_reset();
      test_write_basic();
      test_write_aw_delay();
      test_read_hold();
      test_error_resp();
      test_back_to_back();
      test_cke_freeze();
      test_reset_mid();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog simulation did not finish within time limit");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/iob_iob2axil.md
Name: iob_iob2axil

Overview:
- Bridge from the codebase's IOb native interface (subordinate side) to an AXI-Lite manager; the reverse direction of the existing AXI-Lite-to-IOb converter used by the CSR blocks.
- Lets an IOb-native CPU or DMA reach AXI-Lite peripherals, including the generated CSR banks.
- One outstanding transaction at a time; all AXI-Lite outputs come from registers or are decoded directly from the state register.

Parameters:
- ADDR_W, 32, address width on both interfaces.
- DATA_W, 32, data width; must be a multiple of 8.

Ports:
- clk_i  in  1  clock.
- cke_i  in  1  clock enable; when low, every register holds its value.
- arst_n_i  in  1  reset, asynchronous, active-low.
- iob_valid_i  in  1  request valid; held by the requester until iob_ready_o.
- iob_addr_i  in  ADDR_W  byte address.
- iob_wdata_i  in  DATA_W  write data.
- iob_wstrb_i  in  DATA_W/8  byte strobes; nonzero means write, zero means read.
- iob_ready_o  out  1  request accepted (1-cycle pulse).
- iob_rvalid_o  out  1  read data valid; held until iob_rready_i.
- iob_rdata_o  out  DATA_W  read data.
- iob_rready_i  in  1  requester accepts read data.
- axil_awaddr_o  out  ADDR_W;  axil_awvalid_o  out  1;  axil_awready_i  in  1.
- axil_wdata_o  out  DATA_W;  axil_wstrb_o  out  DATA_W/8;  axil_wvalid_o  out  1;  axil_wready_i  in  1.
- axil_bresp_i  in  2;  axil_bvalid_i  in  1;  axil_bready_o  out  1.
- axil_araddr_o  out  ADDR_W;  axil_arvalid_o  out  1;  axil_arready_i  in  1.
- axil_rdata_i  in  DATA_W;  axil_rresp_i  in  2;  axil_rvalid_i  in  1;  axil_rready_o  out  1.
- resp_err_o  out  1  1-cycle pulse when a BRESP or RRESP is not OKAY (2'b00).

Behaviour:
- Reset: arst_n_i low forces state IDLE asynchronously.
  - All outputs 0: valids, readies, iob_rdata_o, address/data/strobe registers, resp_err_o.
  - Reset mid-transaction abandons the transaction; there is no replay.
- IDLE:
  - On iob_valid_i=1, capture addr, wdata and wstrb into registers.
  - wstrb!=0: go to WR; axil_awvalid_o and axil_wvalid_o go to 1 next cycle.
  - wstrb==0: go to RD_A; axil_araddr_o is driven and axil_arvalid_o goes to 1 next cycle.
- WR:
  - AW and W complete independently.
  - awvalid drops the cycle after the awvalid&awready handshake; wvalid drops the cycle after the wvalid&wready handshake.
  - Two done flags track completion; both handshakes may happen in the same cycle.
  - Once both channels are done, go to WAIT_B.
- WAIT_B:
  - axil_bready_o=1.
  - On bvalid: go to ACK; pulse resp_err_o if bresp!=0.
- ACK: iob_ready_o=1 for exactly 1 cycle, then return to IDLE.
- RD_A: on arvalid&arready, drop arvalid, pulse iob_ready_o the next cycle, go to WAIT_R.
- WAIT_R:
  - axil_rready_o=1.
  - On rvalid: latch rdata into iob_rdata_o, pulse resp_err_o if rresp!=0, go to RVAL.
- RVAL:
  - iob_rvalid_o=1 and iob_rdata_o stable.
  - On iob_rready_i: iob_rvalid_o=0 next cycle, go to IDLE.
- Ordering and stalls:
  - No new request is accepted outside IDLE; iob_ready_o=0 stalls the requester.
  - A new request may be sampled in IDLE in the cycle right after ACK or RVAL ends.
- Latency with zero-wait AXI slave:
  - Write: valid sampled at cycle 0, AW/W at cycle 1, bready at cycle 2, iob_ready_o at cycle 3.
  - Read: iob_ready_o at cycle 2, iob_rvalid_o at cycle 3 at the earliest.
- Address and data output registers hold the captured values until the next request is captured.
- cke_i=0 freezes the FSM and every output register, including in-flight valids.
- Error responses still complete normally: writes are acknowledged, read data is returned as received.

Decomposition:
- Shared package/header holds:
  - FSM state encodings: IDLE, WR, WAIT_B, ACK, RD_A, WAIT_R, RVAL (3 bits).
  - AXI response constants: OKAY=2'b00, SLVERR=2'b10, DECERR=2'b11.
- Registers are built from the existing enable/reset register primitive.
- No new sub-module; the AW/W join logic stays inline.

Test Plan:
1. Write addr=0x10, wdata=0xA5A5_0001, wstrb=0xF, slave zero-wait -> AW/W at cycle 1 carry 0x10/0xA5A50001/0xF; bready at cycle 2; iob_ready_o pulses at cycle 3; resp_err_o stays 0.
2. Write with awready delayed 3 cycles and wready immediate -> wvalid drops after 1 cycle, awvalid held 4 cycles; exactly one B handshake and one iob_ready_o pulse.
3. Read addr=0x8, slave returns rdata=0x0000_0081 two cycles after AR -> iob_ready_o pulses once; iob_rvalid_o=1 with rdata 0x81, held 5 cycles while iob_rready_i=0, then drops 1 cycle after rready.
4. Read returning rresp=SLVERR, then write returning bresp=DECERR -> resp_err_o pulses exactly once per transaction; both transactions still complete.
5. Back-to-back: write then read with iob_valid_i held high -> second request accepted only after ACK; never two AXI valids outstanding.
6. arst_n_i low while in WAIT_B with bvalid never asserted -> all outputs 0 immediately; after release, a fresh read completes normally.
